// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB. It drives the memory
// request strobes, gates register write and PC increment, counts retired
// instructions, and parks in a sticky FAULT state on an illegal opcode or
// on a memory timeout.
//
// Memory handshake: a request (imem_req / dmem_req) is held high for as
// long as the FSM sits in FETCH / MEM. The access completes in the cycle
// where the matching ack is high while the request is high. An ack seen
// when no request is outstanding is ignored. If there is still no ack in
// the cycle where wait_cnt reaches TIMEOUT-1, the FSM goes to FAULT.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             regw,
  output logic             wb_sel,
  output logic             incr,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_ILOAD  = 7'b0000011;
  localparam logic [6:0] OP_SSTORE = 7'b0100011;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             is_load_q, is_load_d;
  logic             is_store_q, is_store_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic op_alu, op_load, op_store;
  logic imem_req_s, ir_load_s, dmem_req_s, dmem_we_s;
  logic regw_s, wb_sel_s, incr_s, fault_s, retire_s;

  assign op_alu   = (opcode == OP_RALU) || (opcode == OP_IALU);
  assign op_load  = (opcode == OP_ILOAD);
  assign op_store = (opcode == OP_SSTORE);

  // State, wait counter, captured opcode class and retired counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_q     <= 8'd0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state and strobe decode from the registered state and same-cycle acks.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    imem_req_s = 1'b0;
    ir_load_s  = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    regw_s     = 1'b0;
    wb_sel_s   = 1'b0;
    incr_s     = 1'b0;
    fault_s    = 1'b0;
    retire_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_load_s = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_q == TO_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = (op_alu || op_load || op_store) ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        // Class is frozen here so the IR may change during MEM/WB.
        is_load_d  = op_load;
        is_store_d = op_store;
        if (op_load || op_store) begin
          state_d = S_MEM;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = is_store_q;
        if (dmem_ack) begin
          if (is_store_q) begin
            incr_s   = 1'b1;
            retire_s = 1'b1;
            state_d  = S_FETCH;
            wait_d   = 8'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TO_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        regw_s   = 1'b1;
        incr_s   = 1'b1;
        wb_sel_s = is_load_q;
        retire_s = 1'b1;
        state_d  = S_FETCH;
        wait_d   = 8'd0;
      end
      S_FAULT: begin
        fault_s = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    retired_d = retire_s ? (retired_q + {{(CNT_W-1){1'b0}}, 1'b1}) : retired_q;
  end

  // Reset forces every strobe low, even though the state already reads FETCH.
  assign imem_req  = imem_req_s & ~reset;
  assign ir_load   = ir_load_s  & ~reset;
  assign dmem_req  = dmem_req_s & ~reset;
  assign dmem_we   = dmem_we_s  & ~reset;
  assign regw      = regw_s     & ~reset;
  assign wb_sel    = wb_sel_s   & ~reset;
  assign incr      = incr_s     & ~reset;
  assign fault     = fault_s    & ~reset;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences for multicycle_ctrl.
// Each instruction is described by opcode and memory wait counts; an
// expected per-cycle output trace is generated from those descriptions.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 32;
  localparam int W       = 8 + CNT_W;

  // Strobe bit positions inside the expected vector's top byte.
  localparam logic [7:0] S_IREQ = 8'h80;
  localparam logic [7:0] S_IRL  = 8'h40;
  localparam logic [7:0] S_DREQ = 8'h20;
  localparam logic [7:0] S_DWE  = 8'h10;
  localparam logic [7:0] S_REGW = 8'h08;
  localparam logic [7:0] S_WBS  = 8'h04;
  localparam logic [7:0] S_INCR = 8'h02;
  localparam logic [7:0] S_FLT  = 8'h01;

  localparam logic [6:0] RALU   = 7'b0110011;
  localparam logic [6:0] IALU   = 7'b0010011;
  localparam logic [6:0] ILOAD  = 7'b0000011;
  localparam logic [6:0] SSTORE = 7'b0100011;
  localparam logic [6:0] ALT    = 7'h7F;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       opcode = 7'd0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             imem_req, ir_load, dmem_req, dmem_we;
  logic             regw, wb_sel, incr, fault;
  logic [CNT_W-1:0] retired;
  logic [2:0]       dbg_state;

  always #5 clock = ~clock;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .ir_load   (ir_load),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .regw      (regw),
    .wb_sel    (wb_sel),
    .incr      (incr),
    .fault     (fault),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  // ---------------- model: stimulus + expected trace ----------------
  logic [9:0]       stim_q[$];   // {reset, opcode, imem_ack, dmem_ack}
  logic [W-1:0]     exp_q[$];    // {strobes, retired}
  logic [CNT_W-1:0] m_ret;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  logic             running = 1'b0;
  logic [W-1:0]     obs [0:63];

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic rst, input logic [6:0] op, input logic ia,
                      input logic da, input logic [7:0] s);
    stim_q.push_back({rst, op, ia, da});
    exp_q.push_back({s, m_ret});
  endtask

  task automatic add_reset(input int n);
    m_ret = '0;
    for (int i = 0; i < n; i++) step(1'b1, 7'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic add_fault(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 7'($urandom_range(0, 127)), rbit(), rbit(), S_FLT);
  endtask

  // iw/dw: cycles without ack before the ack; abort_mem >= 0 asserts reset
  // after that many ack-less MEM cycles; fault_n: FAULT cycles to trace.
  task automatic add_instr(input logic [6:0] op, input int iw, input int dw,
                           input int abort_mem, input int fault_n);
    logic ld, st, legal, ia, da;
    ld    = (op == ILOAD);
    st    = (op == SSTORE);
    legal = ld || st || (op == RALU) || (op == IALU);
    for (int k = 0; ; k++) begin
      ia = (k == iw);
      step(1'b0, op, ia, rbit(), S_IREQ | (ia ? S_IRL : 8'h00));
      if (ia) break;
      if (k == TIMEOUT - 1) begin add_fault(fault_n); return; end
    end
    step(1'b0, op, rbit(), rbit(), 8'h00);              // decode
    if (!legal) begin add_fault(fault_n); return; end
    step(1'b0, op, rbit(), rbit(), 8'h00);              // execute
    if (ld || st) begin
      for (int k = 0; ; k++) begin
        if (abort_mem >= 0 && k == abort_mem) begin add_reset(1); return; end
        da = (k == dw);
        step(1'b0, ALT, rbit(), da,
             S_DREQ | (st ? S_DWE : 8'h00) | ((st && da) ? S_INCR : 8'h00));
        if (da) begin
          if (st) begin m_ret = m_ret + 1; return; end
          break;
        end
        if (k == TIMEOUT - 1) begin add_fault(fault_n); return; end
      end
    end
    step(1'b0, ALT, rbit(), rbit(), S_REGW | S_INCR | (ld ? S_WBS : 8'h00));
    m_ret = m_ret + 1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (running && exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {imem_req, ir_load, dmem_req, dmem_we, regw, wb_sel, incr, fault, retired};
      if (cyc < 64) obs[cyc] = a;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_%0d: got strobes=%b retired=%0d, required strobes=%b retired=%0d (state=%0d)",
                 cyc, a[W-1:CNT_W], a[CNT_W-1:0], e[W-1:CNT_W], e[CNT_W-1:0], dbg_state);
      end
      cyc++;
    end
  end

  task automatic pin(input string name, input int c, input logic [W-1:0] want);
    checks++;
    if (obs[c] !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, obs[c], want);
    end
  endtask

  // ---------------- driver + final report ----------------
  initial begin
    m_ret = '0;
    add_reset(2);
    add_instr(RALU,   0, 0, -1, 0);     // cycles 2..5
    add_instr(IALU,   2, 0, -1, 0);     // cycles 6..11
    add_instr(ILOAD,  0, 3, -1, 0);     // cycles 12..19
    add_instr(SSTORE, 0, 0, -1, 0);     // cycles 20..23
    add_instr(RALU,   0, 0, -1, 0);
    add_instr(7'h7F,  1, 0, -1, 20);    // illegal opcode
    add_reset(1);
    add_instr(RALU, 100, 0, -1, 3);     // fetch timeout
    add_reset(1);
    add_instr(RALU, TIMEOUT - 1, 0, -1, 0);   // ack in last allowed cycle
    add_instr(ILOAD,  0, TIMEOUT - 1, -1, 0); // dmem ack in last cycle
    add_instr(ILOAD,  0, 100, -1, 3);   // data timeout
    add_reset(1);
    add_instr(IALU,   0, 0, -1, 0);
    add_instr(SSTORE, 0, 100, 2, 0);    // reset mid-MEM of a store
    add_instr(SSTORE, 1, 1, -1, 0);
    add_instr(ILOAD,  0, 0, -1, 0);

    running = 1'b1;
    while (stim_q.size() > 0) begin
      logic [9:0] s;
      s = stim_q.pop_front();
      @(posedge clock);
      #1;
      {reset, opcode, imem_ack, dmem_ack} = s;
    end
    @(negedge clock);
    #1;

    pin("add_fetch",     2, {S_IREQ | S_IRL, 32'd0});
    pin("add_wb",        5, {S_REGW | S_INCR, 32'd0});
    pin("add_refetch",   6, {S_IREQ, 32'd1});
    pin("lw_mem_wait",  15, {S_DREQ, 32'd2});
    pin("lw_mem_ack",   18, {S_DREQ, 32'd2});
    pin("lw_wb",        19, {S_REGW | S_WBS | S_INCR, 32'd2});
    pin("sw_mem",       23, {S_DREQ | S_DWE | S_INCR, 32'd3});
    pin("sw_retired",   24, {S_IREQ | S_IRL, 32'd4});

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL trace_drain: got %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Handshakes with the instruction and data memories, and gates the decoder's register-write and PC-increment strobes.
- Gives loads and stores the extra memory cycle(s) they need, and latches a sticky fault on an illegal opcode or a memory timeout.

Parameters:
- TIMEOUT, 15: maximum consecutive cycles a memory request may wait for ack before a fault is raised (legal range 1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- imem_ack  in  1  instruction memory has valid data this cycle.
- dmem_ack  in  1  data memory has completed the access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  capture the instruction word into the IR.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable (store).
- regw  out  1  register file write enable.
- wb_sel  out  1  writeback source: 0 = ALU result, 1 = load data.
- incr  out  1  advance PC by 4.
- fault  out  1  sticky fault flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes:
  - RALU = 7'b0110011
  - IALU = 7'b0010011
  - ILOAD = 7'b0000011
  - SSTORE = 7'b0100011
  - Any other value is illegal.
- Reset (asynchronous, any time, including mid-access):
  - state = FETCH, wait_cnt = 0, fault = 0, retired = 0.
  - All strobes are 0 while reset is high.
  - An outstanding memory request is abandoned; no write or retire occurs.
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. All outputs are decoded from the registered state and the same-cycle ack.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_load = 1 for that cycle, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE (1 cycle):
  - Legal opcode: go to EXEC.
  - Illegal opcode: go to FAULT.
- EXEC (1 cycle; ALU operates):
  - RALU or IALU: go to WB.
  - ILOAD or SSTORE: go to MEM.
- MEM:
  - dmem_req = 1; dmem_we = 1 only for SSTORE.
  - The opcode class is captured in EXEC, so later IR changes do not matter.
  - On dmem_ack, load: go to WB with wb_sel latched to 1.
  - On dmem_ack, store: incr = 1 in the ack cycle, retired += 1, then go to FETCH.
- WB (1 cycle):
  - regw = 1, incr = 1, retired += 1, then go to FETCH.
  - wb_sel = 1 for loads, 0 otherwise.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments each cycle without ack.
  - If there is no ack in the cycle where wait_cnt == TIMEOUT-1, go to FAULT.
  - An ack arriving in that same cycle wins; no fault is raised.
- FAULT:
  - fault = 1.
  - All of imem_req, dmem_req, dmem_we, regw, incr, ir_load = 0.
  - Stays in FAULT until reset; acks are ignored.
- Latency with zero-wait memory:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles (retires in MEM).
- Invariants:
  - incr and retired increment together, exactly once per retired instruction.
  - regw is never asserted for stores.
  - imem_req and dmem_req are never high in the same cycle.
  - retired wraps modulo 2^CNT_W.

Test Plan:
- Reset, then ADD (0110011) with imem_ack tied high: expect ir_load at cycle 0, regw=1 and incr=1 at cycle 3 (wb_sel=0), FETCH again at cycle 4, retired=1.
- LW (0000011) with dmem_ack delayed 3 cycles: dmem_req=1 and dmem_we=0 held for 4 cycles; in the WB cycle after the ack, regw=1 and wb_sel=1; total 8 cycles.
- SW (0100011), immediate acks: dmem_req=1, dmem_we=1, incr=1 in the same MEM cycle; regw stays 0; retired +1; 4 cycles.
- Opcode 7'h7F: DECODE goes to FAULT; fault=1 and stays 1 for 20 cycles of random acks; all strobes 0; retired unchanged.
- TIMEOUT=15 with imem_ack held low: fault rises in cycle 15. Rerun with the ack in cycle 14 (wait_cnt=14): no fault, ir_load=1.
- Assert reset mid-MEM of a store, before the ack: the next cycle shows imem_req=1 (FETCH), fault=0, retired=0, and dmem_req, dmem_we, incr all low.
